// File: rtl/acc_reducer_if.sv
// Bus between the core array / parent core and the accumulator reduction stage.
// The acc_ovf signal exists only when ACC_OVERFLOW_FLAG_EN is defined.
interface acc_reducer_if #(
    parameter int N_CORE = 4,
    parameter int N_ACC  = 2,
    parameter int WIDTH  = 32
);
    localparam int IDX_W = (N_ACC > 1) ? $clog2(N_ACC) : 1;

    logic                            issue_fork;
    logic [N_CORE*N_ACC-1:0]         req_valid;
    logic [N_CORE*N_ACC-1:0]         req_ready;
    logic [N_CORE*N_ACC*WIDTH-1:0]   req_data;
    logic                            wr_en;
    logic [IDX_W-1:0]                wr_idx;
    logic [WIDTH-1:0]                wr_data;
    logic [N_ACC*WIDTH-1:0]          acc_sum;
    logic                            idle;
`ifdef ACC_OVERFLOW_FLAG_EN
    logic [N_ACC-1:0]                acc_ovf;
`endif

    modport master (
        output issue_fork, req_valid, req_data, wr_en, wr_idx, wr_data,
`ifdef ACC_OVERFLOW_FLAG_EN
        input  acc_ovf,
`endif
        input  req_ready, acc_sum, idle
    );

    modport slave (
        input  issue_fork, req_valid, req_data, wr_en, wr_idx, wr_data,
`ifdef ACC_OVERFLOW_FLAG_EN
        output acc_ovf,
`endif
        output req_ready, acc_sum, idle
    );
endinterface

// File: rtl/acc_reducer.sv
// Shared-accumulator reduction stage: per-accumulator round-robin arbitration of core adds.
// Define ACC_OVERFLOW_FLAG_EN to add sticky per-accumulator signed-overflow flags (acc_ovf).
module acc_reducer #(
    parameter int N_CORE = 4,
    parameter int N_ACC  = 2,
    parameter int WIDTH  = 32
) (
    input  logic          clk,
    input  logic          reset,
    acc_reducer_if.slave  bus
);
    localparam int IDX_W = (N_ACC > 1) ? $clog2(N_ACC) : 1;
    localparam int PTR_W = (N_CORE > 1) ? $clog2(N_CORE) : 1;
    localparam int NR    = N_CORE * N_ACC;

    function automatic logic signed [WIDTH-1:0] wrap_add(
        input logic signed [WIDTH-1:0] x,
        input logic signed [WIDTH-1:0] y
    );
        return x + y;
    endfunction

`ifdef ACC_OVERFLOW_FLAG_EN
    function automatic logic add_ovf(
        input logic signed [WIDTH-1:0] x,
        input logic signed [WIDTH-1:0] y,
        input logic signed [WIDTH-1:0] s
    );
        return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    logic [N_ACC-1:0] ovf_q, ovf_d;
`endif

    logic signed [WIDTH-1:0] acc_q [N_ACC];
    logic signed [WIDTH-1:0] acc_d [N_ACC];
    logic [PTR_W-1:0]        ptr_q [N_ACC];
    logic [PTR_W-1:0]        ptr_d [N_ACC];
    logic signed [WIDTH-1:0] add_val [N_ACC];
    logic [N_ACC-1:0]        add_en;
    logic [NR-1:0]           gnt;
    logic                    any_vld_q;

    // Arbitration: each accumulator scans cores starting at its pointer, wrapping.
    always_comb begin
        logic found;
        logic blocked;
        int   c;
        gnt     = '0;
        add_en  = '0;
        found   = 1'b0;
        blocked = 1'b0;
        c       = 0;
        for (int a = 0; a < N_ACC; a++) begin
            add_val[a] = '0;
            ptr_d[a]   = ptr_q[a];
            blocked    = reset || bus.issue_fork || (bus.wr_en && (bus.wr_idx == IDX_W'(a)));
            found      = 1'b0;
            if (bus.issue_fork) begin
                ptr_d[a] = '0;
            end else if (!blocked) begin
                for (int k = 0; k < N_CORE; k++) begin
                    c = (int'(ptr_q[a]) + k) % N_CORE;
                    if (!found && bus.req_valid[c*N_ACC + a]) begin
                        found              = 1'b1;
                        gnt[c*N_ACC + a]   = 1'b1;
                        add_en[a]          = 1'b1;
                        add_val[a]         = bus.req_data[(c*N_ACC + a)*WIDTH +: WIDTH];
                        ptr_d[a]           = PTR_W'((c + 1) % N_CORE);
                    end
                end
            end
        end
    end

    // Accumulator update, priority fork > direct write > add.
    always_comb begin
        logic signed [WIDTH-1:0] sum;
        sum = '0;
`ifdef ACC_OVERFLOW_FLAG_EN
        ovf_d = ovf_q;
`endif
        for (int a = 0; a < N_ACC; a++) begin
            acc_d[a] = acc_q[a];
            sum      = wrap_add(acc_q[a], add_val[a]);
            if (bus.issue_fork) begin
                acc_d[a] = '0;
`ifdef ACC_OVERFLOW_FLAG_EN
                ovf_d[a] = 1'b0;
`endif
            end else if (bus.wr_en && (bus.wr_idx == IDX_W'(a))) begin
                acc_d[a] = bus.wr_data;
`ifdef ACC_OVERFLOW_FLAG_EN
                ovf_d[a] = 1'b0;
`endif
            end else if (add_en[a]) begin
                acc_d[a] = sum;
`ifdef ACC_OVERFLOW_FLAG_EN
                ovf_d[a] = ovf_q[a] | add_ovf(acc_q[a], add_val[a], sum);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < N_ACC; a++) begin
                acc_q[a] <= '0;
                ptr_q[a] <= '0;
            end
            any_vld_q <= 1'b0;
`ifdef ACC_OVERFLOW_FLAG_EN
            ovf_q     <= '0;
`endif
        end else begin
            for (int a = 0; a < N_ACC; a++) begin
                acc_q[a] <= acc_d[a];
                ptr_q[a] <= ptr_d[a];
            end
            any_vld_q <= |bus.req_valid;
`ifdef ACC_OVERFLOW_FLAG_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    always_comb begin
        bus.acc_sum = '0;
        for (int a = 0; a < N_ACC; a++) begin
            bus.acc_sum[a*WIDTH +: WIDTH] = acc_q[a];
        end
    end

    assign bus.req_ready = gnt;
    // Idle only after a full cycle with no request, so the join never races a late valid.
    assign bus.idle      = ~(|bus.req_valid) & ~any_vld_q;
`ifdef ACC_OVERFLOW_FLAG_EN
    assign bus.acc_ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_acc_reducer.sv
// Directed bench for acc_reducer: arbitration order, fork/write priority, wrap, reset mid-loop.
// Overflow-flag checks run only when ACC_OVERFLOW_FLAG_EN is defined.
module tb_acc_reducer;
    localparam int N_CORE = 4;
    localparam int N_ACC  = 2;
    localparam int WIDTH  = 32;
    localparam int NR     = N_CORE * N_ACC;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    acc_reducer_if #(.N_CORE(N_CORE), .N_ACC(N_ACC), .WIDTH(WIDTH)) bus ();

    acc_reducer #(.N_CORE(N_CORE), .N_ACC(N_ACC), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int c, input int a, input logic [WIDTH-1:0] d);
        bus.req_valid[c*N_ACC + a]          = 1'b1;
        bus.req_data[(c*N_ACC + a)*WIDTH +: WIDTH] = d;
    endtask

    task automatic drop(input int c, input int a);
        bus.req_valid[c*N_ACC + a] = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] acc(input int a);
        return bus.acc_sum[a*WIDTH +: WIDTH];
    endfunction

    // A request left unserved must stay valid with unchanged data on the next cycle.
    logic [NR-1:0]    pend;
    logic [WIDTH-1:0] pdata [NR];
    initial pend = '0;
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (pend[i])
                chk("hold", {31'd0, bus.req_valid[i], bus.req_data[i*WIDTH +: WIDTH]},
                    {31'd0, 1'b1, pdata[i]});
            pend[i]  = bus.req_valid[i] & ~bus.req_ready[i];
            pdata[i] = bus.req_data[i*WIDTH +: WIDTH];
        end
    end

    initial begin
        reset          = 1'b1;
        bus.issue_fork = 1'b0;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.wr_en      = 1'b0;
        bus.wr_idx     = '0;
        bus.wr_data    = '0;
        repeat (3) tick();
        #1;
        chk("rst_sum", bus.acc_sum, 0);
        chk("rst_rdy", bus.req_ready, 0);
        chk("rst_idle", bus.idle, 1);
        reset = 1'b0;
        tick();

        // Single add, latency 1, idle deasserts for two cycles
        set_req(1, 0, 5);
        #1;
        chk("t1_rdy", bus.req_ready, 8'h04);
        chk("t1_idle_now", bus.idle, 0);
        tick(); drop(1, 0); #1;
        chk("t1_sum", acc(0), 5);
        chk("t1_idle_late", bus.idle, 0);
        tick(); #1;
        chk("t1_idle_back", bus.idle, 1);

        // Fork clears, then four cores granted in order 0..3
        bus.issue_fork = 1'b1;
        tick(); bus.issue_fork = 1'b0; #1;
        chk("t2_fork_clr", acc(0), 0);
        for (int k = 0; k < N_CORE; k++) set_req(k, 0, WIDTH'(k + 1));
        for (int k = 0; k < N_CORE; k++) begin
            #1;
            chk("t2_rdy", bus.req_ready, 64'(8'(1 << (k*N_ACC))));
            tick(); drop(k, 0);
        end
        #1;
        chk("t2_sum", acc(0), 10);

        // Independent accumulators; ptr back at 0 so core0 wins over core2
        set_req(0, 0, 20); set_req(2, 0, 30); set_req(3, 1, 7);
        #1;
        chk("t3_rdy", bus.req_ready, 8'h81);
        tick(); drop(0, 0); drop(3, 1); #1;
        chk("t3_acc1", acc(1), 7);
        chk("t3_acc0", acc(0), 30);
        chk("t3_rdy2", bus.req_ready, 8'h10);
        tick(); drop(2, 0); #1;
        chk("t3_acc0b", acc(0), 60);

        // Pointer at 3 wraps to core1; negative addend
        set_req(1, 0, 32'hFFFF_FFFB); set_req(2, 0, 5);
        #1;
        chk("wrap_rdy", bus.req_ready, 8'h04);
        tick(); drop(1, 0); #1;
        chk("wrap_acc", acc(0), 55);
        chk("wrap_rdy2", bus.req_ready, 8'h10);
        tick(); drop(2, 0); #1;
        chk("wrap_acc2", acc(0), 60);

        // Fork beats a pending request
        bus.wr_en = 1'b1; bus.wr_idx = 1'b0; bus.wr_data = 9;
        tick(); bus.wr_en = 1'b0; #1;
        chk("t4_wr", acc(0), 9);
        bus.issue_fork = 1'b1; set_req(0, 0, 3);
        #1;
        chk("t4_rdy_fork", bus.req_ready, 0);
        tick(); bus.issue_fork = 1'b0; #1;
        chk("t4_clr", acc(0), 0);
        chk("t4_rdy", bus.req_ready, 8'h01);
        tick(); drop(0, 0); #1;
        chk("t4_sum", acc(0), 3);

        // Direct write blocks only its own accumulator
        bus.wr_en = 1'b1; bus.wr_idx = 1'b1; bus.wr_data = 100;
        set_req(2, 1, 11); set_req(1, 0, 4);
        #1;
        chk("t5_rdy", bus.req_ready, 8'h04);
        tick(); bus.wr_en = 1'b0; drop(1, 0); #1;
        chk("t5_wr", acc(1), 100);
        chk("t5_acc0", acc(0), 7);
        chk("t5_rdy2", bus.req_ready, 8'h20);
        tick(); drop(2, 1); #1;
        chk("t5_sum", acc(1), 111);

        // Modulo 2^WIDTH wrap
        bus.wr_en = 1'b1; bus.wr_idx = 1'b1; bus.wr_data = 32'hFFFF_FFFF;
        tick(); bus.wr_en = 1'b0;
        set_req(0, 1, 2);
        #1;
        chk("mod_rdy", bus.req_ready, 8'h02);
        tick(); drop(0, 1); #1;
        chk("mod_sum", acc(1), 1);

        // Reset mid-loop: pointers return to 0
        set_req(1, 0, 6); set_req(3, 0, 8);
        #1;
        chk("rl_rdy_pre", bus.req_ready, 8'h40);
        reset = 1'b1;
        #1;
        chk("rl_rdy_rst", bus.req_ready, 0);
        tick(); reset = 1'b0; #1;
        chk("rl_acc0", acc(0), 0);
        chk("rl_acc1", acc(1), 0);
        chk("rl_rdy", bus.req_ready, 8'h04);
        tick(); drop(1, 0); #1;
        chk("rl_sum1", acc(0), 6);
        chk("rl_rdy2", bus.req_ready, 8'h40);
        tick(); drop(3, 0); #1;
        chk("rl_sum2", acc(0), 14);

`ifdef ACC_OVERFLOW_FLAG_EN
        bus.wr_en = 1'b1; bus.wr_idx = 1'b0; bus.wr_data = 32'h7FFF_FFFF;
        tick(); bus.wr_en = 1'b0; #1;
        chk("ovf_init", bus.acc_ovf, 0);
        set_req(0, 0, 1);
        #1;
        chk("ovf_rdy", bus.req_ready, 8'h01);
        tick(); #1;
        chk("ovf_sum", acc(0), 32'h8000_0000);
        chk("ovf_set", bus.acc_ovf, 2'b01);
        tick(); drop(0, 0); #1;
        chk("ovf_sum2", acc(0), 32'h8000_0001);
        chk("ovf_sticky", bus.acc_ovf, 2'b01);
        bus.issue_fork = 1'b1;
        tick(); bus.issue_fork = 1'b0; #1;
        chk("ovf_clr", bus.acc_ovf, 0);
`endif

        tick();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
